// File: rtl/step_phase_decoder.sv
// step_phase_decoder: decodes stepper coil phases {A1,B1,A2,B2} into signed position,
// direction, step pulse and activity, flagging skipped phases and illegal patterns.
module step_phase_decoder #(
    parameter int POS_W         = 16,
    parameter int STABLE_CYCLES = 4,
    parameter int IDLE_TIMEOUT  = 1000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    A1,
    input  logic                    B1,
    input  logic                    A2,
    input  logic                    B2,
    input  logic                    clear,
    output logic signed [POS_W-1:0] position,
    output logic        [2:0]       phase,
    output logic                    dir,
    output logic                    step_pulse,
    output logic                    moving,
    output logic                    skip_err,
    output logic                    illegal_err
);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE = 3'd0, P1 = 3'd1, P2 = 3'd2, P3 = 3'd3, P4 = 3'd4} state_t;
    state_t state, state_n, pat;
    logic [3:0] sync1, sync2, prev;
    logic [8:0] cnt, run;
    logic [1:0] d;
    logic accept, legal, dir_n, pulse_n, skip_n, ill_n;
    logic [POS_W-1:0] pos_n;
    logic [TW-1:0] tmr;
    assign phase = state;
    always_comb begin
        pat   = IDLE;
        legal = 1'b1;
        case (sync2)
            4'b0000: pat = IDLE;
            4'b1100: pat = P1;
            4'b0110: pat = P2;
            4'b0011: pat = P3;
            4'b1001: pat = P4;
            default: legal = 1'b0;
        endcase
    end
    // run length of the current synchronized pattern, saturating one past the threshold
    assign run    = (sync2 != prev) ? 9'd1 : (cnt > 9'(STABLE_CYCLES) ? cnt : cnt + 9'd1);
    assign accept = run == 9'(STABLE_CYCLES);
    // phase distance modulo 4: 1 forward, 3 reverse, 2 skip
    assign d      = 2'(pat - state);
    always_comb begin
        state_n = state;
        pos_n   = position;
        dir_n   = dir;
        pulse_n = 1'b0;
        skip_n  = skip_err;
        ill_n   = illegal_err;
        if (accept) begin
            if (!legal) ill_n = 1'b1;
            else if (pat == IDLE || state == IDLE) state_n = pat;
            else begin
                state_n = pat;
                pulse_n = d[0];
                dir_n   = d == 2'd1 ? 1'b1 : d == 2'd3 ? 1'b0 : dir;
                pos_n   = position + (d == 2'd1 ? POS_W'(1) : d == 2'd3 ? {POS_W{1'b1}} : '0);
                skip_n  = skip_err | (d == 2'd2);
            end
        end
        if (clear) begin
            pos_n  = '0;
            skip_n = 1'b0;
            ill_n  = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1       <= '0;
            sync2       <= '0;
            prev        <= '0;
            cnt         <= '0;
            state       <= IDLE;
            position    <= '0;
            dir         <= 1'b0;
            step_pulse  <= 1'b0;
            skip_err    <= 1'b0;
            illegal_err <= 1'b0;
            moving      <= 1'b0;
            tmr         <= '0;
        end else begin
            sync1       <= {A1, B1, A2, B2};
            sync2       <= sync1;
            prev        <= sync2;
            cnt         <= run;
            state       <= state_n;
            position    <= pos_n;
            dir         <= dir_n;
            step_pulse  <= pulse_n;
            skip_err    <= skip_n;
            illegal_err <= ill_n;
            if (pulse_n) begin
                moving <= 1'b1;
                tmr    <= '0;
            end else if (moving) begin
                if (tmr == TW'(IDLE_TIMEOUT - 1)) moving <= 1'b0;
                else tmr <= tmr + TW'(1);
            end
        end
    end
endmodule

// File: tb/tb_step_phase_decoder.sv
// tb_step_phase_decoder: directed coil-pattern vectors with hand-computed expectations.
module tb_step_phase_decoder;
    localparam int TO = 40;
    logic clk = 0, reset = 1, A1 = 0, B1 = 0, A2 = 0, B2 = 0, clear = 0;
    logic signed [3:0] position;
    logic [2:0] phase;
    logic dir, step_pulse, moving, skip_err, illegal_err;
    int n_chk = 0, n_pass = 0, pulses = 0, lat, p0;
    logic [3:0] fwd [4] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100};

    step_phase_decoder #(.POS_W(4), .STABLE_CYCLES(4), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .A1(A1), .B1(B1), .A2(A2), .B2(B2), .clear(clear),
        .position(position), .phase(phase), .dir(dir), .step_pulse(step_pulse),
        .moving(moving), .skip_err(skip_err), .illegal_err(illegal_err)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (step_pulse) pulses++;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic drive(input logic [3:0] p);
        {A1, B1, A2, B2} = p;
    endtask

    task automatic step_to(input logic [3:0] p, output int l);
        drive(p);
        l = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (step_pulse && l < 0) l = i;
        end
    endtask

    initial begin
        #3 reset = 0;
        #1;
        check("rst_position", int'(position), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_dir", int'(dir), 0);
        check("rst_pulse", int'(step_pulse), 0);
        check("rst_moving", int'(moving), 0);
        check("rst_skip", int'(skip_err), 0);
        check("rst_illegal", int'(illegal_err), 0);
        repeat (2) @(negedge clk);
        reset = 1;
        step_to(4'b1100, lat);
        check("energize_lat", lat, -1);
        check("energize_phase", int'(phase), 1);
        check("energize_pos", int'(position), 0);
        for (int i = 0; i < 4; i++) begin
            step_to(fwd[i], lat);
            check("fwd_latency", lat, 6);
        end
        check("fwd_pos", int'(position), 4);
        check("fwd_dir", int'(dir), 1);
        check("fwd_pulses", pulses, 4);
        check("fwd_moving", int'(moving), 1);
        check("fwd_phase", int'(phase), 1);
        step_to(4'b0110, lat);
        step_to(4'b1100, lat);
        check("rev_latency", lat, 6);
        step_to(4'b1001, lat);
        step_to(4'b0011, lat);
        check("rev_pos", int'(position), 2);
        check("rev_dir", int'(dir), 0);
        check("rev_skip", int'(skip_err), 0);
        check("rev_phase", int'(phase), 3);
        step_to(4'b1001, lat);
        step_to(4'b1100, lat);
        p0 = pulses;
        drive(4'b0110);
        repeat (3) @(negedge clk);
        step_to(4'b1100, lat);
        check("glitch_lat", lat, -1);
        check("glitch_pos", int'(position), 4);
        check("glitch_pulses", pulses, p0);
        check("glitch_phase", int'(phase), 1);
        step_to(4'b0011, lat);
        check("skip_flag", int'(skip_err), 1);
        check("skip_pos", int'(position), 4);
        check("skip_phase", int'(phase), 3);
        check("skip_nopulse", lat, -1);
        step_to(4'b1010, lat);
        check("illegal_flag", int'(illegal_err), 1);
        check("illegal_phase", int'(phase), 3);
        check("illegal_pos", int'(position), 4);
        check("illegal_nopulse", lat, -1);
        step_to(4'b1001, lat);
        step_to(4'b1100, lat);
        step_to(4'b0110, lat);
        check("wrap_pre", int'(position), 7);
        step_to(4'b0011, lat);
        check("wrap_fwd", int'(position), -8);
        step_to(4'b0110, lat);
        check("wrap_rev", int'(position), 7);
        check("wrap_dir", int'(dir), 0);
        drive(4'b0011);
        repeat (5) @(negedge clk);
        clear = 1;
        @(negedge clk);
        clear = 0;
        check("clear_pulse", int'(step_pulse), 1);
        check("clear_pos", int'(position), 0);
        check("clear_skip", int'(skip_err), 0);
        check("clear_illegal", int'(illegal_err), 0);
        check("clear_phase", int'(phase), 3);
        repeat (8) @(negedge clk);
        drive(4'b1001);
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(negedge clk);
            if (step_pulse) lat = i;
        end
        check("to_step_lat", lat, 6);
        check("to_pos", int'(position), 1);
        repeat (TO - 1) @(negedge clk);
        check("to_moving_before", int'(moving), 1);
        @(negedge clk);
        check("to_moving_after", int'(moving), 0);
        #2 reset = 0;
        #1;
        check("mid_rst_pos", int'(position), 0);
        check("mid_rst_phase", int'(phase), 0);
        check("mid_rst_dir", int'(dir), 0);
        @(negedge clk);
        reset = 1;
        p0 = pulses;
        step_to(4'b1001, lat);
        check("post_rst_lat", lat, -1);
        check("post_rst_phase", int'(phase), 4);
        check("post_rst_pos", int'(position), 0);
        check("post_rst_pulses", pulses, p0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
